// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the dual-issue pipeline.
// Latches an instruction pair from execute, waits for data-SRAM read data
// when one slot is a load, extracts/extends the loaded value and hands both
// results to write-back. Also drives the memory-stage forwarding bus.
//
// Optional feature macro: MS_LOAD_BYPASS_EN
//   defined   : load_pending drops in the data_ok cycle so decode can take the
//               load result combinationally that cycle.
//   undefined : load_pending stays high until the pair leaves or the read data
//               has been captured in the local buffer.
//
// Handshake: a transfer happens on a clock edge where the producer's valid and
// the consumer's allowin are both high; valid never depends on the consumer's
// allowin, and data is held stable while valid is high and allowin is low.
module mem_stage #(
  parameter int DW        = 32,
  parameter int ES_BUS_WD = 149,
  parameter int MS_BUS_WD = 141,
  parameter int FWD_WD    = 78
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 es_to_ms_valid,
  input  logic [ES_BUS_WD-1:0] es_to_ms_bus,
  output logic                 ms_allowin,
  input  logic                 ws_allowin,
  output logic                 ms_to_ws_valid,
  output logic [MS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                 data_sram_data_ok,
  input  logic [DW-1:0]        data_sram_rdata,
  output logic [FWD_WD-1:0]    ms_forward_bus
);

  // Per-slot fields carried from execute, MSB first.
  typedef struct packed {
    logic          res_from_mem;
    logic [2:0]    ld_type;
    logic          gr_we;
    logic [4:0]    dest;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] pc;
  } es_inst_t;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  logic                 r_ms_valid;
  logic [ES_BUS_WD-1:0] r_es_bus;
  logic                 r_rdata_buf_valid;
  logic [DW-1:0]        r_rdata_buf;

  logic          w_i2_valid;
  es_inst_t      w_i1;
  es_inst_t      w_i2;
  logic          w_has_load;
  logic          w_ready_go;
  logic          w_allowin;
  logic          w_to_ws_valid;
  logic          w_load_pending;
  logic [2:0]    w_ld_type;
  logic [1:0]    w_ld_addr;
  logic [DW-1:0] w_ld_src;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [DW-1:0] w_ld_data;
  logic [DW-1:0] w_i1_result;
  logic [DW-1:0] w_i2_result;

  assign w_i2_valid = r_es_bus[ES_BUS_WD-1];
  assign w_i2       = r_es_bus[2*$bits(es_inst_t)-1:$bits(es_inst_t)];
  assign w_i1       = r_es_bus[$bits(es_inst_t)-1:0];

  // Only one slot can be a load; an invalid inst2 never counts as one.
  assign w_has_load    = r_ms_valid && (w_i1.res_from_mem || (w_i2_valid && w_i2.res_from_mem));
  assign w_ready_go    = !w_has_load || data_sram_data_ok || r_rdata_buf_valid;
  assign w_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign w_to_ws_valid = r_ms_valid && w_ready_go;

`ifdef MS_LOAD_BYPASS_EN
  assign w_load_pending = w_has_load && !r_rdata_buf_valid && !data_sram_data_ok;
`else
  assign w_load_pending = w_has_load && !r_rdata_buf_valid;
`endif

  // Type and address come from whichever slot carries the load.
  assign w_ld_type = w_i1.res_from_mem ? w_i1.ld_type : w_i2.ld_type;
  assign w_ld_addr = w_i1.res_from_mem ? w_i1.alu_result[1:0] : w_i2.alu_result[1:0];
  assign w_ld_src  = r_rdata_buf_valid ? r_rdata_buf : data_sram_rdata;

  // Byte/halfword lane selection from the low address bits.
  always_comb begin
    w_byte = w_ld_src[7:0];
    case (w_ld_addr)
      2'd1:    w_byte = w_ld_src[15:8];
      2'd2:    w_byte = w_ld_src[23:16];
      2'd3:    w_byte = w_ld_src[31:24];
      default: w_byte = w_ld_src[7:0];
    endcase
    w_half = w_ld_addr[1] ? w_ld_src[31:16] : w_ld_src[15:0];
  end

  // Sign/zero extension; unknown load codes behave as a full word.
  always_comb begin
    w_ld_data = w_ld_src;
    case (w_ld_type)
      LD_LB:   w_ld_data = {{(DW-8){w_byte[7]}}, w_byte};
      LD_LBU:  w_ld_data = {{(DW-8){1'b0}}, w_byte};
      LD_LH:   w_ld_data = {{(DW-16){w_half[15]}}, w_half};
      LD_LHU:  w_ld_data = {{(DW-16){1'b0}}, w_half};
      default: w_ld_data = w_ld_src;
    endcase
  end

  assign w_i1_result = w_i1.res_from_mem ? w_ld_data : w_i1.alu_result;
  assign w_i2_result = (w_i2_valid && w_i2.res_from_mem) ? w_ld_data : w_i2.alu_result;

  // Stage-valid bit advances whenever the stage can take a new pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // Pair bus latch: only a real transfer overwrites the held pair.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_es_bus <= '0;
    end else if (es_to_ms_valid && w_allowin) begin
      r_es_bus <= es_to_ms_bus;
    end
  end

  // Read-data buffer: holds returned data while write-back stalls the pair.
  // A data_ok with no waiting load (or buffer already full) is ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata_buf_valid <= 1'b0;
      r_rdata_buf       <= '0;
    end else if (w_to_ws_valid && ws_allowin) begin
      r_rdata_buf_valid <= 1'b0;
    end else if (data_sram_data_ok && w_has_load && !r_rdata_buf_valid && !ws_allowin) begin
      r_rdata_buf_valid <= 1'b1;
      r_rdata_buf       <= data_sram_rdata;
    end
  end

  assign ms_allowin     = w_allowin;
  assign ms_to_ws_valid = w_to_ws_valid;
  assign ms_to_ws_bus   = {w_i2_valid,
                           w_i2.gr_we, w_i2.dest, w_i2_result, w_i2.pc,
                           w_i1.gr_we, w_i1.dest, w_i1_result, w_i1.pc};
  assign ms_forward_bus = {r_ms_valid, w_load_pending,
                           w_i1.gr_we, w_i1.dest, w_i1_result,
                           w_i2.gr_we, w_i2.dest, w_i2_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks for mem_stage (extraction table plus
// multi-cycle stall, buffer, back-to-back and reset sequences).
module tb_mem_stage;

`ifdef MS_LOAD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  localparam logic [2:0] LW = 3'b000, LB = 3'b001, LBU = 3'b010, LH = 3'b011, LHU = 3'b100;
  localparam logic [31:0] R = 32'h8421_F07F;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         resetn;
  logic         es_to_ms_valid;
  logic [148:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         ws_allowin;
  logic         ms_to_ws_valid;
  logic [140:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [77:0]  ms_forward_bus;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk              (clk),
    .resetn           (resetn),
    .es_to_ms_valid   (es_to_ms_valid),
    .es_to_ms_bus     (es_to_ms_bus),
    .ms_allowin       (ms_allowin),
    .ws_allowin       (ws_allowin),
    .ms_to_ws_valid   (ms_to_ws_valid),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .ms_forward_bus   (ms_forward_bus)
  );

  // ---------------- bookkeeping ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [73:0] es_inst(input logic mem, input logic [2:0] ld, input logic we,
                                          input logic [4:0] d, input logic [31:0] alu,
                                          input logic [31:0] pc);
    return {mem, ld, we, d, alu, pc};
  endfunction

  function automatic logic [69:0] ws_inst(input logic we, input logic [4:0] d,
                                          input logic [31:0] res, input logic [31:0] pc);
    return {we, d, res, pc};
  endfunction

  function automatic logic [77:0] fwd(input logic msv, input logic lp,
                                      input logic we1, input logic [4:0] d1, input logic [31:0] r1,
                                      input logic we2, input logic [4:0] d2, input logic [31:0] r2);
    return {msv, lp, we1, d1, r1, we2, d2, r2};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
  endtask

  task automatic drive_pair(input logic [148:0] bus);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        i1_mem;
    logic [2:0]  i1_ld;
    logic [31:0] i1_alu;
    logic        i2_v;
    logic        i2_mem;
    logic [2:0]  i2_ld;
    logic [31:0] i2_alu;
    logic [31:0] rdata;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  function automatic vec_t mk(input logic m1, input logic [2:0] l1, input logic [31:0] a1,
                              input logic v2, input logic m2, input logic [2:0] l2,
                              input logic [31:0] a2, input logic [31:0] rd,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.i1_mem = m1; v.i1_ld = l1; v.i1_alu = a1;
    v.i2_v = v2; v.i2_mem = m2; v.i2_ld = l2; v.i2_alu = a2;
    v.rdata = rd; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  vec_t vecs[16];

  initial begin
    logic [4:0]  d1, d2;
    logic [31:0] pc1, pc2;
    logic        is_load;
    logic [140:0] exp_bus;

    // Hand-computed: R = 8421_F07F -> bytes 7F,F0,21,84; halves F07F,8421.
    vecs[0]  = mk(0, LW,  32'h0000_0011, 1, 0, LW,  32'h0000_0022, 32'h0,        32'h0000_0011, 32'h0000_0022);
    vecs[1]  = mk(1, LB,  32'h2000_0000, 1, 0, LW,  32'h0000_0055, R,            32'h0000_007F, 32'h0000_0055);
    vecs[2]  = mk(1, LB,  32'h2000_0001, 1, 0, LW,  32'h0000_0066, R,            32'hFFFF_FFF0, 32'h0000_0066);
    vecs[3]  = mk(1, LBU, 32'h2000_0001, 1, 0, LW,  32'h0000_0067, R,            32'h0000_00F0, 32'h0000_0067);
    vecs[4]  = mk(1, LB,  32'h2000_0003, 1, 0, LW,  32'h0000_0068, R,            32'hFFFF_FF84, 32'h0000_0068);
    vecs[5]  = mk(1, LH,  32'h2000_0000, 1, 0, LW,  32'h0000_0069, R,            32'hFFFF_F07F, 32'h0000_0069);
    vecs[6]  = mk(1, LHU, 32'h2000_0002, 1, 0, LW,  32'h0000_006A, R,            32'h0000_8421, 32'h0000_006A);
    vecs[7]  = mk(1, LH,  32'h2000_0002, 1, 0, LW,  32'h0000_006B, R,            32'hFFFF_8421, 32'h0000_006B);
    vecs[8]  = mk(0, LW,  32'h0000_0077, 1, 1, LW,  32'h2000_0004, R,            32'h0000_0077, 32'h8421_F07F);
    vecs[9]  = mk(0, LW,  32'h0000_0078, 1, 1, LBU, 32'h2000_0006, R,            32'h0000_0078, 32'h0000_0021);
    vecs[10] = mk(1, 3'b111, 32'h2000_0003, 1, 0, LW, 32'h0000_0079, R,          32'h8421_F07F, 32'h0000_0079);
    vecs[11] = mk(0, LW,  32'h0000_0099, 0, 0, LW,  32'h0000_00AA, 32'h0,        32'h0000_0099, 32'h0000_00AA);
    vecs[12] = mk(1, LB,  32'h2000_0003, 1, 0, LW,  32'h0000_007A, 32'h80FF_0000, 32'hFFFF_FF80, 32'h0000_007A);
    vecs[13] = mk(0, LW,  32'h0000_007B, 1, 1, LHU, 32'h2000_0002, 32'hBEEF_1234, 32'h0000_007B, 32'h0000_BEEF);
    vecs[14] = mk(1, LHU, 32'h2000_0000, 1, 0, LW,  32'h0000_007C, R,            32'h0000_F07F, 32'h0000_007C);
    vecs[15] = mk(1, LH,  32'h2000_0001, 1, 0, LW,  32'h0000_007D, R,            32'hFFFF_F07F, 32'h0000_007D);

    // ---------------- reset state ----------------
    resetn = 1'b0;
    ws_allowin = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_valid",   ms_to_ws_valid, 0);
    chk("reset_allowin", ms_allowin, 1);
    chk("reset_fwd",     ms_forward_bus, 0);
    chk("reset_ws_bus",  ms_to_ws_bus, 0);
    @(negedge clk);
    resetn = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 16; i++) begin
      d1  = 5'(i + 3);
      d2  = 5'(i + 4);
      pc1 = 32'h0000_1000 + 32'(8 * i);
      pc2 = pc1 + 32'd4;
      is_load = vecs[i].i1_mem || (vecs[i].i2_v && vecs[i].i2_mem);

      @(negedge clk);
      ws_allowin = 1'b1;
      drive_pair({vecs[i].i2_v,
                  es_inst(vecs[i].i2_mem, vecs[i].i2_ld, vecs[i].i2_v, d2, vecs[i].i2_alu, pc2),
                  es_inst(vecs[i].i1_mem, vecs[i].i1_ld, 1'b1, d1, vecs[i].i1_alu, pc1)});
      #1 chk($sformatf("v%0d_accept_allowin", i), ms_allowin, 1);

      @(negedge clk);
      idle_inputs();
      if (is_load) begin
        #1;
        chk($sformatf("v%0d_wait_valid", i), ms_to_ws_valid, 0);
        chk($sformatf("v%0d_wait_allowin", i), ms_allowin, 0);
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = vecs[i].rdata;
      end
      #1;
      exp_bus = {vecs[i].i2_v, ws_inst(vecs[i].i2_v, d2, vecs[i].exp2, pc2),
                 ws_inst(1'b1, d1, vecs[i].exp1, pc1)};
      chk($sformatf("v%0d_out_valid", i), ms_to_ws_valid, 1);
      chk($sformatf("v%0d_ws_bus", i), ms_to_ws_bus, exp_bus);
      chk($sformatf("v%0d_fwd_bus", i), ms_forward_bus,
          fwd(1'b1, is_load && !BYPASS, 1'b1, d1, vecs[i].exp1, vecs[i].i2_v, d2, vecs[i].exp2));

      @(negedge clk);
      idle_inputs();
      #1 chk($sformatf("v%0d_drained", i), ms_to_ws_valid, 0);
    end

    // ---------------- lb with data_ok three cycles after acceptance ----------------
    @(negedge clk);
    ws_allowin = 1'b1;
    drive_pair({1'b1, es_inst(0, LW, 1, 5'd9, 32'h33, 32'h2004),
                es_inst(1, LB, 1, 5'd8, 32'h2000_0003, 32'h2000)});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 3) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_0000;
      end
      #1;
      chk($sformatf("lb3_c%0d_valid", c), ms_to_ws_valid, (c == 3));
      chk($sformatf("lb3_c%0d_allowin", c), ms_allowin, (c == 3));
    end
    chk("lb3_ws_bus", ms_to_ws_bus,
        {1'b1, ws_inst(1, 5'd9, 32'h33, 32'h2004), ws_inst(1, 5'd8, 32'hFFFF_FF80, 32'h2000)});
    @(negedge clk);
    idle_inputs();

    // ---------------- lhu buffered while write-back stalls ----------------
    drive_pair({1'b1, es_inst(1, LHU, 1, 5'd12, 32'h2000_0002, 32'h3004),
                es_inst(0, LW, 1, 5'd11, 32'h44, 32'h3000)});
    exp_bus = {1'b1, ws_inst(1, 5'd12, 32'h0000_BEEF, 32'h3004), ws_inst(1, 5'd11, 32'h44, 32'h3000)};
    @(negedge clk);
    idle_inputs();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1234;
    #1;
    chk("buf_dok_valid",   ms_to_ws_valid, 1);
    chk("buf_dok_allowin", ms_allowin, 0);
    chk("buf_dok_lp",      ms_forward_bus[76], !BYPASS);
    chk("buf_dok_bus",     ms_to_ws_bus, exp_bus);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      idle_inputs();
      ws_allowin = (c == 1);
      #1;
      chk($sformatf("buf_hold%0d_valid", c), ms_to_ws_valid, 1);
      chk($sformatf("buf_hold%0d_bus", c), ms_to_ws_bus, exp_bus);
      chk($sformatf("buf_hold%0d_lp", c), ms_forward_bus[76], 0);
      chk($sformatf("buf_hold%0d_allowin", c), ms_allowin, (c == 1));
    end
    // Buffer must be clear: a new lw with no data_ok cannot complete.
    @(negedge clk);
    drive_pair({1'b0, es_inst(0, LW, 0, 5'd0, 32'h0, 32'h0),
                es_inst(1, LW, 1, 5'd13, 32'h2000_0040, 32'h3100)});
    #1 chk("buf_idle_valid", ms_to_ws_valid, 0);
    @(negedge clk);
    idle_inputs();
    #1 chk("buf_cleared_valid", ms_to_ws_valid, 0);

    // ---------------- bypass check on lw with write-back stalled ----------------
    @(negedge clk);
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hDEAD_BEEF;
    #1;
    chk("byp_lp",  ms_forward_bus[76], !BYPASS);
    chk("byp_fwd_res", ms_forward_bus[69:38], 32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs();
    ws_allowin = 1'b1;
    #1;
    chk("byp_release_bus", ms_to_ws_bus,
        {1'b0, ws_inst(0, 5'd0, 32'h0, 32'h0), ws_inst(1, 5'd13, 32'hDEAD_BEEF, 32'h3100)});
    @(negedge clk);

    // ---------------- three back-to-back non-load pairs ----------------
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 3) begin
        drive_pair({1'b1, es_inst(0, LW, 1, 5'(20 + k), 32'(k), 32'h4004 + 32'(8 * k)),
                    es_inst(0, LW, 1, 5'(24 + k), 32'(k), 32'h4000 + 32'(8 * k))});
        exp_q.push_back(32'h4000 + 32'(8 * k));
      end else begin
        idle_inputs();
      end
      #1;
      if (k < 3) chk($sformatf("b2b%0d_allowin", k), ms_allowin, 1);
      if (k >= 1 && k <= 3) begin
        chk($sformatf("b2b%0d_valid", k), ms_to_ws_valid, 1);
        chk($sformatf("b2b%0d_pc", k), ms_to_ws_bus[31:0], exp_q.pop_front());
      end else if (k == 4) begin
        chk("b2b_end_valid", ms_to_ws_valid, 0);
      end
    end

    // ---------------- reset while lw waits ----------------
    @(negedge clk);
    drive_pair({1'b0, es_inst(0, LW, 0, 5'd0, 32'h0, 32'h0),
                es_inst(1, LW, 1, 5'd5, 32'h2000_0010, 32'h5000)});
    @(negedge clk);
    idle_inputs();
    #1 chk("rst_pre_lp", ms_forward_bus[76], 1);
    #2 resetn = 1'b0;
    #1;
    chk("rst_valid",   ms_to_ws_valid, 0);
    chk("rst_lp",      ms_forward_bus[76], 0);
    chk("rst_msvalid", ms_forward_bus[77], 0);
    chk("rst_allowin", ms_allowin, 1);
    @(negedge clk);
    resetn = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hFFFF_FFFF;
    #1;
    chk("stale_valid", ms_to_ws_valid, 0);
    chk("stale_lp",    ms_forward_bus[76], 0);
    @(negedge clk);
    idle_inputs();
    ws_allowin = 1'b0;
    drive_pair({1'b0, es_inst(0, LW, 0, 5'd0, 32'h0, 32'h0),
                es_inst(1, LW, 1, 5'd6, 32'h2000_0020, 32'h5100)});
    @(negedge clk);
    idle_inputs();
    #1 chk("fresh_wait_valid", ms_to_ws_valid, 0);
    @(negedge clk);
    ws_allowin        = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    #1;
    chk("fresh_valid", ms_to_ws_valid, 1);
    chk("fresh_bus", ms_to_ws_bus,
        {1'b0, ws_inst(0, 5'd0, 32'h0, 32'h0), ws_inst(1, 5'd6, 32'h1234_5678, 32'h5100)});
    @(negedge clk);
    idle_inputs();

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the dual-issue pipeline.
- Sits between the execute stage and the write-back stage.
- Accepts an instruction pair from execute and waits for data-SRAM read data when either slot is a load.
- Extracts and extends the loaded byte, halfword or word, then hands both results to write-back. Also drives the memory-stage forwarding bus to decode.

Parameters:
- DW, 32, data/address width.
- ES_BUS_WD, 149, execute-to-memory bus width.
- MS_BUS_WD, 141, memory-to-write-back bus width.
- FWD_WD, 78, forwarding bus width.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  asynchronous active-low reset.
- es_to_ms_valid  in  1  execute holds a valid pair.
- es_to_ms_bus  in  149  pair bus, MSB first:
  - inst2_valid
  - inst2 {res_from_mem, ld_type[2:0], gr_we, dest[4:0], alu_result[31:0], pc[31:0]}
  - inst1 {same fields}
- ms_allowin  out  1  memory stage can accept a pair this cycle.
- ws_allowin  in  1  write-back can accept.
- ms_to_ws_valid  out  1  pair complete and valid.
- ms_to_ws_bus  out  141  pair bus, MSB first:
  - inst2_valid
  - inst2 {gr_we, dest, final_result, pc}
  - inst1 {gr_we, dest, final_result, pc}
- data_sram_data_ok  in  1  read data returned this cycle.
- data_sram_rdata  in  32  read data.
- ms_forward_bus  out  78  {ms_valid, load_pending, inst1 gr_we/dest/result, inst2 gr_we/dest/result}.

Behaviour:
- Reset (asynchronous, resetn low) clears ms_valid, the latched bus, rdata_buf_valid and rdata_buf. Outputs follow immediately: ms_to_ws_valid=0, ms_allowin=1, load_pending=0.
- ld_type encoding: 000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; other codes behave as lw.
- Pair acceptance: the bus is latched when es_to_ms_valid && ms_allowin. On ms_allowin, ms_valid <= es_to_ms_valid.
- At most one slot has res_from_mem=1; the other slot's result is alu_result.
- has_load = ms_valid && (inst1.res_from_mem || (inst2_valid && inst2.res_from_mem)).
- ms_ready_go = !has_load || data_sram_data_ok || rdata_buf_valid.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go.
- Read-data buffer:
  - If data_sram_data_ok arrives while has_load && !rdata_buf_valid && !ws_allowin, capture rdata into rdata_buf and set rdata_buf_valid.
  - rdata_buf_valid clears when the pair leaves (ms_to_ws_valid && ws_allowin).
  - Load data source = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- data_ok with no waiting load (!has_load, or buffer already full) is a protocol error. It is ignored and must not alter state; the bench flags it.
- Extraction uses load addr = alu_result[1:0] of the load slot:
  - lb/lbu select byte addr[1:0], sign- or zero-extended.
  - lh/lhu select halfword addr[1] (0 = bits 15:0), sign- or zero-extended.
  - lw passes the word through.
- Latency:
  - Non-load pair: 1 cycle in stage (ms_to_ws_valid the cycle after acceptance).
  - Load pair: completes in the data_ok cycle, or later if stalled.
- Back-to-back: a new pair may be accepted in the same cycle the previous one leaves.
- An inst2_valid=0 pair forwards inst2 fields unchanged. Write-back qualifies them with inst2_valid.
- Forward bus:
  - ms_valid: raw stage-valid bit.
  - load_pending = has_load && !rdata_buf_valid (modified by the optional feature).
  - Results are the final_result values; a load slot shows extracted data.

Optional Feature:
- Macro: MS_LOAD_BYPASS_EN.
- Defined: load_pending is also deasserted in the data_ok cycle (load_pending = has_load && !rdata_buf_valid && !data_sram_data_ok). Decode may forward the load result combinationally that cycle.
- Undefined: load_pending stays high until the pair has left, or until rdata_buf_valid is set. A consumer therefore stalls at least until the cycle after data_ok.

Test Plan:
- Non-load pair inst1 {gr_we=1, dest=3, alu=0x11}, inst2_valid=1 {dest=4, alu=0x22}, ws_allowin=1 -> ms_to_ws_valid next cycle with results 0x11/0x22.
- inst1 lb with addr low bits 2'b11, rdata=0x80FF_0000, data_ok 3 cycles after acceptance -> ms_to_ws_valid only in data_ok cycle, result 0xFFFF_FF80. ms_allowin low during the wait.
- inst2 lhu with addr[1]=1, rdata=0xBEEF_1234, data_ok while ws_allowin=0 for 2 cycles -> buffered; on release result 0x0000_BEEF, buffer cleared.
- Three consecutive non-load pairs with ws_allowin=1 -> one pair per cycle, no bubbles, PCs in order.
- resetn pulled low while a lw waits for data_ok -> ms_to_ws_valid=0 and load_pending=0 immediately. After release the stage accepts a fresh pair and a stale data_ok is ignored.
- Bypass check, lw rdata=0xDEAD_BEEF -> with macro, load_pending=0 in the data_ok cycle. Without macro, load_pending=1 in that cycle (when ws_allowin=0).
